// File: rtl/truth_table_scanner_if.sv
// truth_table_scanner_if
//   Bundles the scan control, the stimulus/response pair for the unit under
//   test, and the captured results of truth_table_scanner.
//   slave  : the scanner side (drives abc and the results, consumes start/y).
//   master : the controller / unit side (drives start and y).
//   Signals:
//     start     begin a scan (honoured only while idle)
//     abc       stimulus {A,B,C} to the unit
//     y         unit output, combinational function of abc
//     busy      scan in progress
//     done      one-cycle completion pulse
//     table_out captured truth table, bit k = y for vector k
//     pass      table_out matches the golden table
//     fail_mask bitwise difference from the golden table
interface truth_table_scanner_if;
    logic       start;
    logic [2:0] abc;
    logic       y;
    logic       busy;
    logic       done;
    logic [7:0] table_out;
    logic       pass;
    logic [7:0] fail_mask;

    modport slave (
        input  start, y,
        output abc, busy, done, table_out, pass, fail_mask
    );

    modport master (
        output start, y,
        input  abc, busy, done, table_out, pass, fail_mask
    );
endinterface

// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//   Exhaustive stimulus-and-capture stage for a 3-input combinational unit.
//   On start it drives abc through 000..111, holds each vector HOLD_CYCLES
//   cycles, samples y on the last cycle of each hold into table_out, then
//   pulses done.
//   Parameters:
//     HOLD_CYCLES  cycles each vector is held before y is sampled (1..255)
//     EXPECTED     golden truth table, bit k = required y for vector k
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    truth_table_scanner_if.slave (start, abc, y, busy, done,
//            table_out, pass, fail_mask)
//   Build option:
//     SCAN_CHECK_EN  when defined, pass/fail_mask compare table_out against
//                    EXPECTED; when undefined both outputs are tied to 0.
module truth_table_scanner #(
    parameter int         HOLD_CYCLES = 4,
    parameter logic [7:0] EXPECTED    = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst_n,
    truth_table_scanner_if.slave     bus
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state, state_nxt;
    logic [2:0] idx;
    logic [7:0] hold;
    logic [2:0] abc_q;
    logic [7:0] table_q;
    logic [7:0] table_nxt;
    logic       last_hold;
    logic       busy, done;

    assign last_hold = (hold == HOLD_LAST);

    // Table as it will look after this cycle's capture; used so the compare
    // result is already valid during the DONE cycle.
    always_comb begin
        table_nxt      = table_q;
        table_nxt[idx] = bus.y;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_hold && idx == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

`ifdef SCAN_CHECK_EN
    logic       pass_q;
    logic [7:0] fail_q;
`endif

    // Scan datapath: vector index, hold counter, registered stimulus, capture.
    // abc is registered one step ahead so the new vector appears on the same
    // edge that captures y for the previous one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx     <= 3'd0;
            hold    <= 8'd0;
            abc_q   <= 3'd0;
            table_q <= 8'h00;
`ifdef SCAN_CHECK_EN
            pass_q  <= 1'b0;
            fail_q  <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx     <= 3'd0;
                        hold    <= 8'd0;
                        abc_q   <= 3'd0;
                        table_q <= 8'h00;
`ifdef SCAN_CHECK_EN
                        pass_q  <= 1'b0;
                        fail_q  <= 8'h00;
`endif
                    end
                end
                RUN: begin
                    if (last_hold) begin
                        table_q <= table_nxt;
                        hold    <= 8'd0;
                        if (idx == 3'd7) begin
                            abc_q  <= 3'd0;
`ifdef SCAN_CHECK_EN
                            pass_q <= (table_nxt == EXPECTED);
                            fail_q <= table_nxt ^ EXPECTED;
`endif
                        end else begin
                            idx   <= idx + 3'd1;
                            abc_q <= idx + 3'd1;
                        end
                    end else begin
                        hold <= hold + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.abc       = abc_q;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.table_out = table_q;
`ifdef SCAN_CHECK_EN
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_q;
`else
    assign bus.pass      = 1'b0;
    assign bus.fail_mask = 8'h00;
`endif

endmodule
